tcp_vlg_ack_tx: RTL and testbench
=================================

TCP_VLG_ACK_TX -- requirements
Module: tcp_vlg_ack_tx

Interface
REQ-001 SHALL have parameter ARB_TIMEOUT, default 2500, cycles spent in ARB before stall_err is raised.
REQ-002 SHALL have parameter WND_W, default 16, width of the advertised window field.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port send  in  1  pure-ack request level from the ack generator; held until sent.
REQ-006 SHALL have port sent  out  1  one-cycle pulse confirming the request is satisfied.
REQ-007 SHALL have port conn  in  1  connection in tcp_connected state.
REQ-008 SHALL have port data_busy  in  1  data tx path currently owns the header/tx channel.
REQ-009 SHALL have port data_ack_sent  in  1  pulse: data segment carrying current tcb_loc_ack was transmitted.
REQ-010 SHALL have ports tcb_loc_seq / tcb_loc_ack  in  32 each  local sequence and ack numbers.
REQ-011 SHALL have ports tcb_loc_port / tcb_rem_port  in  16 each  local and remote port.
REQ-012 SHALL have port tcb_wnd  in  WND_W  receive window to advertise.
REQ-013 SHALL have port hdr_val  out  1  header valid toward the tcp tx header builder.
REQ-014 SHALL have port hdr_rdy  in  1  header accepted by the builder.
REQ-015 SHALL have ports hdr_seq / hdr_ack (32 each), hdr_src_port / hdr_dst_port (16 each), hdr_wnd (WND_W), hdr_flags (8)  out  latched pure-ack header fields.
REQ-016 SHALL have port ack_cnt  out  16  count of pure acks emitted.
REQ-017 SHALL have port stall_err  out  1  sticky ARB timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, ARB, HDR, DONE.
REQ-019 IDLE->ARB SHALL occur when send && conn && !sent; in all other cases the FSM stays in IDLE.
REQ-020 ARB->IDLE SHALL occur with no sent pulse when conn=0.
REQ-021 ARB->DONE SHALL occur when data_ack_sent=1 (ack piggybacked on data; no header emitted); this SHALL take priority over the grant.
REQ-022 ARB->HDR SHALL occur when !data_busy, latching on that edge: hdr_seq=tcb_loc_seq, hdr_ack=tcb_loc_ack, hdr_src_port=tcb_loc_port, hdr_dst_port=tcb_rem_port, hdr_wnd=tcb_wnd, hdr_flags=8'h10 (ACK only).
REQ-023 hdr_val SHALL be 1 exactly in HDR; all hdr_* fields SHALL be stable while hdr_val=1.
REQ-024 HDR SHALL exit only on hdr_val && hdr_rdy, ignoring conn, data_busy and data_ack_sent.
REQ-025 HDR->DONE SHALL occur on that handshake; ack_cnt SHALL increment by 1 (wrapping 16'hFFFF->0) on the same edge.
REQ-026 sent SHALL equal 1 exactly in DONE, for one cycle, and DONE SHALL always go to IDLE; latency from handshake to sent is 1 cycle.
REQ-027 The minimum send-to-hdr_val latency SHALL be 2 cycles (IDLE->ARB->HDR).
REQ-028 An ARB cycle counter SHALL clear on ARB entry and saturate at ARB_TIMEOUT; at equality stall_err SHALL set, with the FSM still waiting in ARB.
REQ-029 stall_err SHALL clear only on the next sent pulse or on reset.
REQ-030 A send still high in the cycle after DONE SHALL be treated as a new request.

Reset
REQ-031 Asserting rst (low) at any time SHALL force IDLE, with sent=0, hdr_val=0, all hdr_* fields=0, ack_cnt=0, stall_err=0, and the ARB counter=0.
REQ-032 Reset asserted mid-HDR SHALL drop hdr_val immediately (asynchronous) with no sent pulse; deassertion SHALL be synchronised to clk.

Configuration
REQ-033 The macro TCP_VLG_ACK_TX_DUP_SUPPRESS_EN SHALL control duplicate suppression.
REQ-034 With TCP_VLG_ACK_TX_DUP_SUPPRESS_EN defined, the block SHALL record ack and wnd of the last emitted pure ack; on ARB->HDR, if tcb_loc_ack and tcb_wnd both equal the record and a record exists, the FSM SHALL go to DONE instead (sent pulses, no header, ack_cnt unchanged); the record SHALL be invalidated on reset and whenever conn=0.
REQ-035 With TCP_VLG_ACK_TX_DUP_SUPPRESS_EN undefined, every grant SHALL emit a header and the record logic SHALL be absent.

Verification
REQ-036 send=1, conn=1, data_busy=0, hdr_rdy=1, tcb_loc_ack=32'h1000 -> hdr_val high at cycle 2 with hdr_ack=32'h1000 and flags=8'h10; sent at cycle 3; ack_cnt=1.
REQ-037 data_busy=1 for 10 cycles then 0, with tcb_loc_ack changing from 5 to 9 during the wait -> hdr_ack=9 (latched at the grant edge).
REQ-038 In ARB, pulse data_ack_sent -> sent pulses next cycle, hdr_val never asserts, ack_cnt unchanged.
REQ-039 ARB_TIMEOUT=8, data_busy held high -> stall_err=1 after 8 ARB cycles; release -> header emitted, stall_err clears with sent.
REQ-040 hdr_rdy=0 for 5 cycles in HDR while tcb fields and conn toggle -> hdr_* fields stable; rst low in HDR -> hdr_val=0 immediately and no sent.
REQ-041 DUP_SUPPRESS_EN defined, two requests with identical ack=32'h20 and wnd=16'h400 -> one header emitted, two sent pulses, ack_cnt=1.

Source files
------------

// File: rtl/tcp_vlg_ack_tx_if.sv
// Header channel between the pure-ack transmitter and the tcp tx header builder.
// The master drives a latched header with hdr_val; the slave accepts it with hdr_rdy.
interface tcp_vlg_ack_tx_if #(
  parameter int WND_W = 16
);
  logic             hdr_val;
  logic             hdr_rdy;
  logic [31:0]      hdr_seq;
  logic [31:0]      hdr_ack;
  logic [15:0]      hdr_src_port;
  logic [15:0]      hdr_dst_port;
  logic [WND_W-1:0] hdr_wnd;
  logic [7:0]       hdr_flags;

  modport master (
    output hdr_val,
    output hdr_seq,
    output hdr_ack,
    output hdr_src_port,
    output hdr_dst_port,
    output hdr_wnd,
    output hdr_flags,
    input  hdr_rdy
  );

  modport slave (
    input  hdr_val,
    input  hdr_seq,
    input  hdr_ack,
    input  hdr_src_port,
    input  hdr_dst_port,
    input  hdr_wnd,
    input  hdr_flags,
    output hdr_rdy
  );
endinterface

// File: rtl/tcp_vlg_ack_tx.sv
// Pure-ack transmitter: arbitrates for the tx header channel and emits an ACK-only header.
// Optional duplicate suppression is enabled by defining TCP_VLG_ACK_TX_DUP_SUPPRESS_EN.
module tcp_vlg_ack_tx #(
  parameter int ARB_TIMEOUT = 2500,
  parameter int WND_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  output logic                  sent,
  input  logic                  conn,
  input  logic                  data_busy,
  input  logic                  data_ack_sent,
  input  logic [31:0]           tcb_loc_seq,
  input  logic [31:0]           tcb_loc_ack,
  input  logic [15:0]           tcb_loc_port,
  input  logic [15:0]           tcb_rem_port,
  input  logic [WND_W-1:0]      tcb_wnd,
  tcp_vlg_ack_tx_if.master      hdr,
  output logic [15:0]           ack_cnt,
  output logic                  stall_err
);

  localparam int CNT_W = (ARB_TIMEOUT < 1) ? 1 : $clog2(ARB_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ARB_TIMEOUT);
  localparam logic [7:0] FLAGS_ACK = 8'h10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HDR  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             latch_hdr;
  logic             handshake;
  logic             dup_hit;
  logic [CNT_W-1:0] arb_cnt;
  logic [CNT_W-1:0] arb_cnt_nxt;

  assign sent        = (state == DONE);
  assign hdr.hdr_val = (state == HDR);
  assign handshake   = hdr.hdr_val && hdr.hdr_rdy;

`ifdef TCP_VLG_ACK_TX_DUP_SUPPRESS_EN
  logic             rec_vld;
  logic [31:0]      rec_ack;
  logic [WND_W-1:0] rec_wnd;

  assign dup_hit = rec_vld && (tcb_loc_ack == rec_ack) && (tcb_wnd == rec_wnd);

  // Remember what the peer last heard from us; a dropped connection forgets it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_vld <= 1'b0;
      rec_ack <= '0;
      rec_wnd <= '0;
    end else if (!conn) begin
      rec_vld <= 1'b0;
    end else if (handshake) begin
      rec_vld <= 1'b1;
      rec_ack <= hdr.hdr_ack;
      rec_wnd <= hdr.hdr_wnd;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    latch_hdr = 1'b0;
    unique case (state)
      IDLE: begin
        if (send && conn && !sent) state_nxt = ARB;
      end
      ARB: begin
        // A piggybacked ack on data satisfies the request even if the channel is free.
        if (!conn) begin
          state_nxt = IDLE;
        end else if (data_ack_sent) begin
          state_nxt = DONE;
        end else if (!data_busy) begin
          if (dup_hit) begin
            state_nxt = DONE;
          end else begin
            state_nxt = HDR;
            latch_hdr = 1'b1;
          end
        end
      end
      HDR: begin
        if (handshake) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    arb_cnt_nxt = arb_cnt;
    if (state != ARB) begin
      arb_cnt_nxt = '0;
    end else if (arb_cnt != CNT_MAX) begin
      arb_cnt_nxt = arb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      arb_cnt <= '0;
    end else begin
      state   <= state_nxt;
      arb_cnt <= arb_cnt_nxt;
    end
  end

  // Header fields are captured only at the grant edge so they stay frozen during HDR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr.hdr_seq      <= '0;
      hdr.hdr_ack      <= '0;
      hdr.hdr_src_port <= '0;
      hdr.hdr_dst_port <= '0;
      hdr.hdr_wnd      <= '0;
      hdr.hdr_flags    <= '0;
    end else if (latch_hdr) begin
      hdr.hdr_seq      <= tcb_loc_seq;
      hdr.hdr_ack      <= tcb_loc_ack;
      hdr.hdr_src_port <= tcb_loc_port;
      hdr.hdr_dst_port <= tcb_rem_port;
      hdr.hdr_wnd      <= tcb_wnd;
      hdr.hdr_flags    <= FLAGS_ACK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_cnt <= '0;
    end else if (handshake) begin
      ack_cnt <= ack_cnt + 16'd1;
    end
  end

  // Stall is sticky until the request finally completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_err <= 1'b0;
    end else if (sent) begin
      stall_err <= 1'b0;
    end else if ((state == ARB) && (arb_cnt_nxt == CNT_MAX)) begin
      stall_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcp_vlg_ack_tx.sv
// Self-checking bench for tcp_vlg_ack_tx: vector table, corner sequences and random transactions.
// Duplicate-suppression expectations follow TCP_VLG_ACK_TX_DUP_SUPPRESS_EN.
module tb_tcp_vlg_ack_tx;
  localparam int TMO   = 8;
  localparam int WND_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             send;
  logic             sent;
  logic             conn;
  logic             data_busy;
  logic             data_ack_sent;
  logic [31:0]      tcb_loc_seq;
  logic [31:0]      tcb_loc_ack;
  logic [15:0]      tcb_loc_port;
  logic [15:0]      tcb_rem_port;
  logic [WND_W-1:0] tcb_wnd;
  logic [15:0]      ack_cnt;
  logic             stall_err;

  tcp_vlg_ack_tx_if #(.WND_W(WND_W)) hdr_bus ();

  tcp_vlg_ack_tx #(.ARB_TIMEOUT(TMO), .WND_W(WND_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .send          (send),
    .sent          (sent),
    .conn          (conn),
    .data_busy     (data_busy),
    .data_ack_sent (data_ack_sent),
    .tcb_loc_seq   (tcb_loc_seq),
    .tcb_loc_ack   (tcb_loc_ack),
    .tcb_loc_port  (tcb_loc_port),
    .tcb_rem_port  (tcb_rem_port),
    .tcb_wnd       (tcb_wnd),
    .hdr           (hdr_bus),
    .ack_cnt       (ack_cnt),
    .stall_err     (stall_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               busy;
    int               rdy_dly;
    int               piggy;
    logic [31:0]      ack;
    logic [WND_W-1:0] wnd;
    bit               exp_hdr;
    int               exp_sent;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
`ifdef TCP_VLG_ACK_TX_DUP_SUPPRESS_EN
  bit               rec_vld = 1'b0;
  logic [31:0]      rec_ack = '0;
  logic [WND_W-1:0] rec_wnd = '0;
`endif

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    send          = 1'b0;
    conn          = 1'b1;
    data_busy     = 1'b0;
    data_ack_sent = 1'b0;
    hdr_bus.hdr_rdy = 1'b0;
  endtask

  task automatic rand_tcb();
    tcb_loc_seq  = $urandom;
    tcb_loc_ack  = $urandom;
    tcb_loc_port = 16'($urandom);
    tcb_rem_port = 16'($urandom);
    tcb_wnd      = WND_W'($urandom);
  endtask

  // Reference outcome of one request from the protocol rules alone.
  task automatic predict(input int busy, input int rdy_dly, input int piggy,
                         input logic [31:0] a, input logic [WND_W-1:0] w,
                         output bit h, output int s);
    bit dup;
    dup = 1'b0;
`ifdef TCP_VLG_ACK_TX_DUP_SUPPRESS_EN
    dup = rec_vld && (a == rec_ack) && (w == rec_wnd);
`endif
    if (piggy > 0) begin
      h = 1'b0;
      s = piggy + 1;
    end else if (dup) begin
      h = 1'b0;
      s = busy + 2;
    end else begin
      h = 1'b1;
      s = busy + 3 + rdy_dly;
    end
  endtask

  // One request starting #1 after a rising edge; cycle 0 is the IDLE cycle where send rises.
  task automatic apply_stimulus(input string name, input int busy, input int rdy_dly, input int piggy,
                                input logic [31:0] g_ack, input logic [WND_W-1:0] g_wnd,
                                input bit exp_hdr, input int exp_sent);
    int          g;
    int          arb_cyc;
    int          done_arb;
    int          hv_cyc;
    int          sent_cyc;
    logic [31:0] e_seq, e_ack;
    logic [15:0] e_src, e_dst;
    logic [WND_W-1:0] e_wnd;
    g        = busy + 1;
    arb_cyc  = (piggy > 0) ? piggy : g;
    hv_cyc   = -1;
    sent_cyc = -1;
    e_seq = '0; e_ack = '0; e_src = '0; e_dst = '0; e_wnd = '0;
    for (int c = 0; (c <= busy + rdy_dly + 8) && (sent_cyc < 0); c++) begin
      send          = 1'b1;
      conn          = 1'b1;
      data_busy     = (c >= 1) && (c <= busy);
      data_ack_sent = (piggy > 0) && (c == piggy);
      rand_tcb();
      if (c == g) begin
        tcb_loc_ack = g_ack;
        tcb_wnd     = g_wnd;
        e_seq = tcb_loc_seq; e_ack = tcb_loc_ack; e_src = tcb_loc_port;
        e_dst = tcb_rem_port; e_wnd = tcb_wnd;
      end
      hdr_bus.hdr_rdy = (c >= g + 1 + rdy_dly);
      @(negedge clk);
      if (hdr_bus.hdr_val) begin
        if (hv_cyc < 0) hv_cyc = c;
        if (exp_hdr) begin
          check_output({name, "_seq"}, hdr_bus.hdr_seq, e_seq);
          check_output({name, "_ack"}, hdr_bus.hdr_ack, e_ack);
          check_output({name, "_src"}, hdr_bus.hdr_src_port, e_src);
          check_output({name, "_dst"}, hdr_bus.hdr_dst_port, e_dst);
          check_output({name, "_wnd"}, hdr_bus.hdr_wnd, e_wnd);
          check_output({name, "_flags"}, hdr_bus.hdr_flags, 8'h10);
        end
      end
      done_arb = (c == 0) ? 0 : (((c - 1) < arb_cyc) ? (c - 1) : arb_cyc);
      check_output({name, "_stall"}, stall_err, done_arb >= TMO);
      if (sent) begin
        sent_cyc = c;
        send = 1'b0;
      end
      @(posedge clk); #1;
    end
    check_output({name, "_hv_cycle"}, 64'(hv_cyc), exp_hdr ? 64'(g + 1) : 64'(-1));
    check_output({name, "_sent_cycle"}, 64'(sent_cyc), 64'(exp_sent));
    if (exp_hdr) begin
      exp_cnt = exp_cnt + 16'd1;
`ifdef TCP_VLG_ACK_TX_DUP_SUPPRESS_EN
      rec_vld = 1'b1; rec_ack = g_ack; rec_wnd = g_wnd;
`endif
    end
    drive_idle();
    @(negedge clk);
    check_output({name, "_sent_once"}, sent, 1'b0);
    check_output({name, "_hv_off"}, hdr_bus.hdr_val, 1'b0);
    check_output({name, "_stall_clr"}, stall_err, 1'b0);
    check_output({name, "_ack_cnt"}, ack_cnt, exp_cnt);
    @(posedge clk); #1;
  endtask

  vec_t vecs[9];

  initial begin
    int busy, rdy, piggy, s;
    bit h;
    logic [31:0] last_ack, a, k_seq, k_ack;
    logic [WND_W-1:0] last_wnd, w;
    int sent_a, sent_b;

    vecs[0] = '{0,  0, 0, 32'h0000_1000, 16'h0100, 1'b1, 3};
    vecs[1] = '{10, 0, 0, 32'h0000_0009, 16'h0200, 1'b1, 13};
    vecs[2] = '{3,  2, 2, 32'h0000_0055, 16'h0300, 1'b0, 3};
    vecs[3] = '{0,  0, 1, 32'h0000_0066, 16'h0301, 1'b0, 2};
    vecs[4] = '{2,  5, 0, 32'h0000_0077, 16'h0302, 1'b1, 10};
    vecs[5] = '{7,  1, 0, 32'h0000_0088, 16'h0303, 1'b1, 11};
    vecs[6] = '{6,  0, 0, 32'h0000_0099, 16'h0304, 1'b1, 9};
    vecs[7] = '{1,  0, 0, 32'h0000_0020, 16'h0400, 1'b1, 4};
`ifdef TCP_VLG_ACK_TX_DUP_SUPPRESS_EN
    vecs[8] = '{0,  1, 0, 32'h0000_0020, 16'h0400, 1'b0, 2};
`else
    vecs[8] = '{0,  1, 0, 32'h0000_0020, 16'h0400, 1'b1, 4};
`endif

    rst = 1'b0;
    drive_idle();
    rand_tcb();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_hdr_val", hdr_bus.hdr_val, 1'b0);
    check_output("rst_sent", sent, 1'b0);
    check_output("rst_ack_cnt", ack_cnt, 16'd0);
    check_output("rst_stall", stall_err, 1'b0);
    check_output("rst_hdr_ack", hdr_bus.hdr_ack, 32'd0);
    check_output("rst_hdr_flags", hdr_bus.hdr_flags, 8'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].busy, vecs[i].rdy_dly, vecs[i].piggy,
                     vecs[i].ack, vecs[i].wnd, vecs[i].exp_hdr, vecs[i].exp_sent);
    end

    // send held across DONE starts a second request from the following IDLE cycle
    sent_a = 0; sent_b = 0;
    for (int c = 0; c < 10; c++) begin
      send = (c <= 7);
      conn = 1'b1; data_busy = 1'b0; data_ack_sent = 1'b0; hdr_bus.hdr_rdy = 1'b1;
      rand_tcb();
      @(negedge clk);
      if (sent) begin
        if (c == 3 || c == 7) sent_a++; else sent_b++;
      end
      check_output($sformatf("b2b_hv_c%0d", c), hdr_bus.hdr_val, (c == 2) || (c == 6));
      @(posedge clk); #1;
    end
    check_output("b2b_sent_expected", 64'(sent_a), 64'd2);
    check_output("b2b_sent_stray", 64'(sent_b), 64'd0);
    exp_cnt = exp_cnt + 16'd2;
    drive_idle();
    @(negedge clk);
    check_output("b2b_ack_cnt", ack_cnt, exp_cnt);
    @(posedge clk); #1;

    // connection drops while arbitrating: request abandoned silently
    sent_b = 0;
    for (int c = 0; c < 9; c++) begin
      send = (c <= 7);
      conn = !(c >= 3 && c <= 7);
      data_busy = 1'b1; data_ack_sent = 1'b0; hdr_bus.hdr_rdy = 1'b1;
      rand_tcb();
      @(negedge clk);
      if (sent || hdr_bus.hdr_val) sent_b++;
      @(posedge clk); #1;
    end
`ifdef TCP_VLG_ACK_TX_DUP_SUPPRESS_EN
    rec_vld = 1'b0;
`endif
    check_output("abort_no_activity", 64'(sent_b), 64'd0);
    drive_idle();
    @(negedge clk);
    check_output("abort_ack_cnt", ack_cnt, exp_cnt);
    check_output("abort_stall", stall_err, 1'b0);
    @(posedge clk); #1;

    // stall in HDR with churning inputs, then an asynchronous reset
    send = 1'b1; conn = 1'b1; data_busy = 1'b0; hdr_bus.hdr_rdy = 1'b0;
    rand_tcb();
    @(posedge clk); #1;
    rand_tcb();
    k_seq = tcb_loc_seq; k_ack = tcb_loc_ack;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      rand_tcb();
      conn = c[0];
      data_busy = 1'(~c[0]);
      data_ack_sent = c[1];
      @(negedge clk);
      check_output($sformatf("hold_hv_%0d", c), hdr_bus.hdr_val, 1'b1);
      check_output($sformatf("hold_seq_%0d", c), hdr_bus.hdr_seq, k_seq);
      check_output($sformatf("hold_ack_%0d", c), hdr_bus.hdr_ack, k_ack);
      if (c < 4) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b0;
    #1;
    check_output("arst_hv", hdr_bus.hdr_val, 1'b0);
    check_output("arst_sent", sent, 1'b0);
    check_output("arst_hdr_ack", hdr_bus.hdr_ack, 32'd0);
    check_output("arst_ack_cnt", ack_cnt, 16'd0);
    exp_cnt = '0;
`ifdef TCP_VLG_ACK_TX_DUP_SUPPRESS_EN
    rec_vld = 1'b0;
`endif
    drive_idle();
    sent_b = 0;
    repeat (2) begin
      @(negedge clk);
      if (sent || hdr_bus.hdr_val) sent_b++;
    end
    check_output("arst_no_sent", 64'(sent_b), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    last_ack = 32'h20; last_wnd = 16'h400;
    for (int i = 0; i < 24; i++) begin
      busy  = int'($urandom_range(0, 12));
      rdy   = int'($urandom_range(0, 4));
      piggy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, busy + 1)) : 0;
      if ($urandom_range(0, 3) == 0) begin
        a = last_ack; w = last_wnd;
      end else begin
        a = $urandom; w = WND_W'($urandom);
      end
      predict(busy, rdy, piggy, a, w, h, s);
      apply_stimulus($sformatf("rnd%0d", i), busy, rdy, piggy, a, w, h, s);
      if (h) begin
        last_ack = a; last_wnd = w;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
